branch_unit: RTL
================

Name: branch_unit

Overview:
- Branch/jump functional unit; sits downstream of the reservation station as a peer of the integer execution unit.
- Resolves JAL, JALR and the six conditional branches. Queues results in an output FIFO, requests the common data bus (CDB) through the arbiter, and broadcasts link value, target address and redirect flag to the reorder buffer.
- Fetch always predicts sequential, so a taken branch or any jump carries redirect=1.

Parameters:
DATA_WIDTH, 32, operand/result width
ADDR_WIDTH, 32, instruction address width
TAG_WIDTH, 6, ROB tag width
BRU_FIFO_DEPTH, 8, output FIFO entries (power of 2, >=4)

Ports:
clk  in  1  clock
n_rst  in  1  asynchronous active-low reset
i_flush  in  1  ROB redirect; squash all in-flight work
i_valid  in  1  RS issues an op this cycle
i_opcode  in  7  insn[6:0]; JAL=1101111, JALR=1100111, BRANCH=1100011
i_iaddr  in  ADDR_WIDTH  instruction address
i_insn  in  32  raw instruction
i_src_a  in  DATA_WIDTH  rs1 value
i_src_b  in  DATA_WIDTH  rs2 value
i_tag  in  TAG_WIDTH  destination ROB tag
o_stall  out  1  RS must not issue next cycle
o_arb_req  out  1  CDB request
i_arb_gnt  in  1  CDB grant, same cycle as request
o_cdb_en  out  1  CDB valid
o_cdb_data  out  DATA_WIDTH  link value
o_cdb_addr  out  ADDR_WIDTH  resolved next PC
o_cdb_tag  out  TAG_WIDTH  ROB tag
o_cdb_redirect  out  1  fetch must redirect to o_cdb_addr

Behaviour:
- Reset, asynchronous on n_rst low:
  - S1/S2 valid bits cleared; FIFO pointers and count set to 0.
  - o_arb_req=0, o_stall=0; o_cdb_* high-Z.
  - Reset mid-operation discards everything.
- Pipeline:
  - S0 (issue edge): register i_* into S1 when i_valid && !i_flush.
  - S1: decode the immediate (I, B or J format, sign-extended to ADDR_WIDTH) and evaluate the compare.
  - S2: compute target and link; write the FIFO at the end of S2.
  - Issue at edge N produces a FIFO entry visible at N+2, so o_arb_req is high from cycle N+2. Minimum issue-to-CDB latency is 2 cycles.
- Result computation:
  - link = iaddr+4, wrapping modulo 2^ADDR_WIDTH.
  - JAL: addr = iaddr+immJ; data = link; redirect=1.
  - JALR: addr = (src_a+immI) & ~1; data = link; redirect=1.
  - BRANCH, funct3 selects the compare:
    - 000 BEQ, 001 BNE.
    - 100 BLT and 101 BGE, signed.
    - 110 BLTU and 111 BGEU, unsigned.
  - BRANCH taken: addr = iaddr+immB; redirect=1; data=0.
  - BRANCH not taken: addr = link; redirect=0; data=0.
  - BRANCH with funct3 010 or 011, or an unknown opcode: treated as not-taken, redirect=0, data=0.
  - Target misalignment is not checked.
- CDB handshake:
  - o_arb_req = FIFO non-empty && !i_flush.
  - When i_arb_gnt=1, drive o_cdb_en=1 and the head entry on the o_cdb_* outputs, and pop at the clock edge.
  - When i_arb_gnt=0, all o_cdb_* are high-Z.
  - One broadcast per cycle maximum.
- Flow control:
  - o_stall = (count + S1.valid + S2.valid) >= BRU_FIFO_DEPTH-1. This is a registered credit, so an op issued in the cycle stall rises still fits.
  - The FIFO never overflows. A write to a full FIFO is a design error; assert in simulation.
  - Simultaneous push and pop: count unchanged; both pointers advance and wrap modulo depth.
- Flush:
  - i_flush high at an edge clears S1/S2 valid and empties the FIFO (pointers to 0).
  - An i_valid in the same cycle is dropped.
  - o_arb_req is forced low during the flush cycle. A granted broadcast already driven in that cycle is not suppressed; the ROB ignores it.
- Redirect-producing results need no ordering with other units; the ROB orders retirement by tag.

Decomposition:
- Shared types package:
  - opcode constants OPCODE_JAL, OPCODE_JALR, OPCODE_BRANCH.
  - funct3 enum for branch compares.
  - packed struct bru_result_t {redirect, addr, data, tag}.
- Reuse the existing sync_fifo for the output queue, DATA_WIDTH = $bits(bru_result_t), flush tied to i_flush.
- Compare/immediate logic stays inline.

Test Plan:
- BEQ, iaddr=0x100, src_a=src_b=5, immB=+16 -> 2 cycles later CDB tag=T, addr=0x110, redirect=1, data=0.
- BLT signed, src_a=0xFFFFFFFF, src_b=1 -> taken; same operands under BLTU -> not taken, addr=0x104, redirect=0.
- JALR, iaddr=0x200, src_a=0x1003, immI=0 -> addr=0x1002, data=0x204, redirect=1.
- i_arb_gnt held 0 with back-to-back issues -> o_stall high once 7 ops are in flight. FIFO holds 8 ops and never overflows. Releasing the grant drains the results in issue order, one per cycle.
- i_flush while FIFO holds 3 entries and S1/S2 are valid -> next cycle o_arb_req=0, count=0, and no stale broadcast afterwards.
- n_rst low mid-drain -> o_arb_req=0 immediately, o_cdb_* high-Z, and nothing is broadcast after n_rst returns high.

Source files
------------

// File: rtl/branch_unit_pkg.sv
// Shared types for the branch unit: RISC-V opcodes, branch compare encodings
// and the result record that travels through the output queue to the CDB.
package branch_unit_pkg;

    localparam int BRU_DATA_WIDTH = 32;
    localparam int BRU_ADDR_WIDTH = 32;
    localparam int BRU_TAG_WIDTH  = 6;

    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;

    typedef enum logic [2:0] {
        F3_BEQ  = 3'b000,
        F3_BNE  = 3'b001,
        F3_BLT  = 3'b100,
        F3_BGE  = 3'b101,
        F3_BLTU = 3'b110,
        F3_BGEU = 3'b111
    } bru_funct3_e;

    // What S2 must do with the operands captured from S1.
    typedef enum logic [1:0] {
        KIND_NONE,
        KIND_JAL,
        KIND_JALR,
        KIND_TAKEN
    } bru_kind_e;

    typedef struct packed {
        logic                      redirect;
        logic [BRU_ADDR_WIDTH-1:0] addr;
        logic [BRU_DATA_WIDTH-1:0] data;
        logic [BRU_TAG_WIDTH-1:0]  tag;
    } bru_result_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous flush; DEPTH must be a power of two so
// the pointers wrap naturally.
module sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic [DATA_WIDTH-1:0]    i_data,
    input  logic                     i_pop,
    output logic [DATA_WIDTH-1:0]    o_data,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [AW:0]           r_count;
    logic                  w_full;
    logic                  w_do_push;
    logic                  w_do_pop;

    assign o_empty   = (r_count == '0);
    assign w_full    = (r_count == (AW+1)'(DEPTH));
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!w_full || w_do_pop);
    assign o_data    = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
    end

    // Upstream credit logic guarantees room; a push into a full queue is a bug.
    assert property (@(posedge clk) disable iff (!n_rst)
        !(i_push && w_full && !i_pop && !i_flush));

endmodule

// File: rtl/branch_unit.sv
// Branch/jump unit: S1 decodes immediate and compare, S2 forms target and
// link, results queue in a FIFO and are broadcast on the CDB when granted.
module branch_unit
    import branch_unit_pkg::*;
#(
    parameter int DATA_WIDTH     = BRU_DATA_WIDTH,
    parameter int ADDR_WIDTH     = BRU_ADDR_WIDTH,
    parameter int TAG_WIDTH      = BRU_TAG_WIDTH,
    parameter int BRU_FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  i_flush,
    input  logic                  i_valid,
    input  logic [6:0]            i_opcode,
    input  logic [ADDR_WIDTH-1:0] i_iaddr,
    input  logic [31:0]           i_insn,
    input  logic [DATA_WIDTH-1:0] i_src_a,
    input  logic [DATA_WIDTH-1:0] i_src_b,
    input  logic [TAG_WIDTH-1:0]  i_tag,
    output logic                  o_stall,
    output logic                  o_arb_req,
    input  logic                  i_arb_gnt,
    output logic                  o_cdb_en,
    output logic [DATA_WIDTH-1:0] o_cdb_data,
    output logic [ADDR_WIDTH-1:0] o_cdb_addr,
    output logic [TAG_WIDTH-1:0]  o_cdb_tag,
    output logic                  o_cdb_redirect
);

    localparam int CW = $clog2(BRU_FIFO_DEPTH) + 1;

    logic                  r_s1_valid;
    logic [6:0]            r_s1_opcode;
    logic [ADDR_WIDTH-1:0] r_s1_iaddr;
    logic [31:7]           r_s1_insn;
    logic [DATA_WIDTH-1:0] r_s1_src_a;
    logic [DATA_WIDTH-1:0] r_s1_src_b;
    logic [TAG_WIDTH-1:0]  r_s1_tag;

    logic                  r_s2_valid;
    bru_kind_e             r_s2_kind;
    logic [ADDR_WIDTH-1:0] r_s2_imm;
    logic [ADDR_WIDTH-1:0] r_s2_iaddr;
    logic [ADDR_WIDTH-1:0] r_s2_base;
    logic [TAG_WIDTH-1:0]  r_s2_tag;

    logic                  r_stall;

    logic [ADDR_WIDTH-1:0] w_imm_i, w_imm_b, w_imm_j, w_imm;
    logic [2:0]            w_funct3;
    logic                  w_taken;
    bru_kind_e             w_kind;
    logic [ADDR_WIDTH-1:0] w_link;
    bru_result_t           w_result, w_head;
    logic                  w_empty, w_bcast;
    logic [CW-1:0]         w_count, w_count_next;
    logic [CW:0]           w_inflight_next;
    logic                  w_unused;

    assign w_unused = ^i_insn[6:0];

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_stall    <= 1'b0;
        end else begin
            r_s1_valid <= i_valid && !i_flush;
            r_s2_valid <= r_s1_valid && !i_flush;
            r_stall    <= (w_inflight_next >= (CW+1)'(BRU_FIFO_DEPTH - 1));
        end
    end

    always_ff @(posedge clk) begin
        if (i_valid) begin
            r_s1_opcode <= i_opcode;
            r_s1_iaddr  <= i_iaddr;
            r_s1_insn   <= i_insn[31:7];
            r_s1_src_a  <= i_src_a;
            r_s1_src_b  <= i_src_b;
            r_s1_tag    <= i_tag;
        end
        if (r_s1_valid) begin
            r_s2_kind  <= w_kind;
            r_s2_imm   <= w_imm;
            r_s2_iaddr <= r_s1_iaddr;
            r_s2_base  <= ADDR_WIDTH'(r_s1_src_a);
            r_s2_tag   <= r_s1_tag;
        end
    end

    assign w_funct3 = r_s1_insn[14:12];
    assign w_imm_i  = ADDR_WIDTH'($signed(r_s1_insn[31:20]));
    assign w_imm_b  = ADDR_WIDTH'($signed({r_s1_insn[31], r_s1_insn[7], r_s1_insn[30:25],
                                           r_s1_insn[11:8], 1'b0}));
    assign w_imm_j  = ADDR_WIDTH'($signed({r_s1_insn[31], r_s1_insn[19:12], r_s1_insn[20],
                                           r_s1_insn[30:21], 1'b0}));

    always_comb begin
        w_taken = 1'b0;
        case (w_funct3)
            F3_BEQ:  w_taken = (r_s1_src_a == r_s1_src_b);
            F3_BNE:  w_taken = (r_s1_src_a != r_s1_src_b);
            F3_BLT:  w_taken = ($signed(r_s1_src_a) <  $signed(r_s1_src_b));
            F3_BGE:  w_taken = ($signed(r_s1_src_a) >= $signed(r_s1_src_b));
            F3_BLTU: w_taken = (r_s1_src_a <  r_s1_src_b);
            F3_BGEU: w_taken = (r_s1_src_a >= r_s1_src_b);
            default: w_taken = 1'b0;
        endcase
    end

    // Anything that is neither a jump nor a taken branch falls through to PC+4.
    always_comb begin
        w_kind = KIND_NONE;
        w_imm  = w_imm_b;
        if (r_s1_opcode == OPCODE_JAL) begin
            w_kind = KIND_JAL;
            w_imm  = w_imm_j;
        end else if (r_s1_opcode == OPCODE_JALR) begin
            w_kind = KIND_JALR;
            w_imm  = w_imm_i;
        end else if (r_s1_opcode == OPCODE_BRANCH && w_taken) begin
            w_kind = KIND_TAKEN;
        end
    end

    assign w_link = r_s2_iaddr + ADDR_WIDTH'(4);

    always_comb begin
        w_result.redirect = 1'b0;
        w_result.addr     = w_link;
        w_result.data     = '0;
        w_result.tag      = r_s2_tag;
        case (r_s2_kind)
            KIND_JAL: begin
                w_result.redirect = 1'b1;
                w_result.addr     = r_s2_iaddr + r_s2_imm;
                w_result.data     = DATA_WIDTH'(w_link);
            end
            KIND_JALR: begin
                w_result.redirect = 1'b1;
                w_result.addr     = (r_s2_base + r_s2_imm) & ~ADDR_WIDTH'(1);
                w_result.data     = DATA_WIDTH'(w_link);
            end
            KIND_TAKEN: begin
                w_result.redirect = 1'b1;
                w_result.addr     = r_s2_iaddr + r_s2_imm;
            end
            default: ;
        endcase
    end

    sync_fifo #(
        .DATA_WIDTH ($bits(bru_result_t)),
        .DEPTH      (BRU_FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .n_rst   (n_rst),
        .i_flush (i_flush),
        .i_push  (r_s2_valid),
        .i_data  (w_result),
        .i_pop   (w_bcast),
        .o_data  (w_head),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Credit counts everything that will occupy the queue after this edge.
    always_comb begin
        w_count_next = w_count;
        if (r_s2_valid && !w_bcast)      w_count_next = w_count + 1'b1;
        else if (!r_s2_valid && w_bcast) w_count_next = w_count - 1'b1;
        if (i_flush) w_inflight_next = '0;
        else         w_inflight_next = {1'b0, w_count_next}
                                     + {{CW{1'b0}}, i_valid}
                                     + {{CW{1'b0}}, r_s1_valid};
    end

    assign w_bcast        = i_arb_gnt && !w_empty;
    assign o_arb_req      = !w_empty && !i_flush;
    assign o_stall        = r_stall;
    assign o_cdb_en       = w_bcast ? 1'b1          : 1'bz;
    assign o_cdb_data     = w_bcast ? w_head.data     : {DATA_WIDTH{1'bz}};
    assign o_cdb_addr     = w_bcast ? w_head.addr     : {ADDR_WIDTH{1'bz}};
    assign o_cdb_tag      = w_bcast ? w_head.tag      : {TAG_WIDTH{1'bz}};
    assign o_cdb_redirect = w_bcast ? w_head.redirect : 1'bz;

endmodule
